jk_mod_counter: RTL and testbench
=================================

// Module: jk_mod_counter
// PURPOSE
//  Parametrised WIDTH-bit register whose bits are JK flip-flops. It runs as a modulo-MODULUS
//  up/down counter, as a parallel-load register, or as a raw per-bit JK bank (J/K driven directly).
//  It is the generalised successor of the single JK flip-flop and the building block for the
//  counter/sequencer examples; all next-state logic is derived as per-bit J/K equations.
// PARAMETERS
//  WIDTH      4   number of JK bits in q (>=1)
//  MODULUS    16  count modulus for up/down modes, 2 <= MODULUS <= 2**WIDTH
//  RESET_VAL  0   value forced onto q by reset_async (must be < MODULUS)
// PORTS
//  clk          in   1      rising-edge clock
//  reset_async  in   1      asynchronous reset, active-high; q <= RESET_VAL immediately
//  load         in   1      synchronous parallel load of load_val (highest synchronous priority)
//  load_val     in   WIDTH  value captured when load=1
//  en           in   1      count/JK enable; en=0 holds q (load still honoured)
//  mode         in   2      00 hold, 01 count up, 10 count down, 11 raw JK bank
//  j_in         in   WIDTH  per-bit J, used only in mode 11
//  k_in         in   WIDTH  per-bit K, used only in mode 11
//  q            out  WIDTH  register state
//  tc           out  1      terminal count (combinational from q, mode, en)
// BEHAVIOUR
//  - Reset: reset_async=1 forces q=RESET_VAL asynchronously and holds it while asserted; tc follows q.
//  - Release: the first rising edge after deassertion applies normal next-state.
//  - Priority at each rising edge: load > (en & mode) > hold.
//  - load=1: q <= load_val verbatim, even if load_val >= MODULUS; en, mode and J/K are ignored.
//  - en=0 or mode=00: q holds.
//  - mode=01 (up): q <= q+1; if q == MODULUS-1, q <= 0.
//  - mode=10 (down): q <= q-1; if q == 0, q <= MODULUS-1.
//  - Out-of-range q (>= MODULUS, reached only via load or JK mode): next count in either direction is 0.
//  - mode=11 (JK bank), per bit i: JK=00 hold; 01 q[i]<=0; 10 q[i]<=1; 11 q[i]<=~q[i].
//    Modulus is not applied; out-of-range results are legal.
//  - Count modes are realised as J=K=toggle-enable per bit. The modulus wrap forces J/K to
//    clear or set the bits, so no extra adder path exists.
//  - tc = en & ~load & ((mode==01 & q==MODULUS-1) | (mode==10 & q==0)); tc=0 in modes 00 and 11.
//  - Latency: q changes one clock edge after inputs are sampled; tc has zero-cycle latency from q.
//  - MODULUS = 2**WIDTH gives natural binary wrap with no compare; the behaviour is identical.
//  - Reset mid-count: q jumps to RESET_VAL with no clock; any pending load or count is discarded.
// TESTING (WIDTH=4, MODULUS=10, RESET_VAL=0 unless noted)
//  1 Async reset: pulse reset_async between clock edges while q=7.
//    -> q=0 before the next edge; q held at 0 while reset is high.
//  2 Up wrap: en=1, mode=01, starting from 0, run 12 edges.
//    -> q = 1..9,0,1,2; tc=1 only while q=9.
//  3 Down wrap: en=1, mode=10, from q=2, run 4 edges.
//    -> q = 1,0,9,8; tc=1 only while q=0.
//  4 Load priority and out-of-range: load=1, load_val=13, mode=01, en=0.
//    -> q=13. Next edge with load=0, en=1, mode=01 -> q=0.
//  5 JK bank: q=4'b1010, mode=11, en=1, j_in=4'b0011, k_in=4'b0101.
//    -> bits[3:0] take JK 00,01,10,11 -> q=4'b1011.
//  6 Hold and enable: mode=00 or en=0 for 3 edges -> q unchanged, tc=0.
//    Run the MODULUS=16 build and count up from 15 -> 0 with tc=1 at 15.

Source files
------------

// File: rtl/jk_mod_counter.sv
// WIDTH-bit register built from JK flip-flops: modulo up/down counter, parallel load, or raw JK bank.
// All next-state behaviour is expressed as per-bit J/K drive; there is no adder or mux path on q.

module jk_mod_counter_bit #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);
  logic q_d, q_q;

  always_comb begin
    q_d = q_q;
    case ({j, k})
      2'b00: q_d = q_q;
      2'b01: q_d = 1'b0;
      2'b10: q_d = 1'b1;
      2'b11: q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= RST_BIT;
    else     q_q <= q_d;
  end

  assign q = q_q;
endmodule

module jk_mod_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset_async,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j_in,
  input  logic [WIDTH-1:0] k_in,
  output logic [WIDTH-1:0] q,
  output logic             tc
);
  typedef enum logic [1:0] {
    M_HOLD = 2'b00,
    M_UP   = 2'b01,
    M_DN   = 2'b10,
    M_JK   = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  mode_e            mode_s;
  logic [WIDTH-1:0] j_bit, k_bit;
  logic [WIDTH-1:0] t_up, t_dn;
  logic             at_max, at_zero, oor;

  assign mode_s  = mode_e'(mode);
  assign at_max  = (q == MAX_V);
  assign at_zero = (q == '0);

  // A full power-of-two modulus can never be exceeded, so no range compare is built.
  generate
    if (MODULUS < (2 ** WIDTH)) begin : g_oor
      localparam logic [WIDTH-1:0] MOD_V = WIDTH'(MODULUS);
      assign oor = (q >= MOD_V);
    end else begin : g_no_oor
      assign oor = 1'b0;
    end
  endgenerate

  // Bit i toggles when all lower bits are 1 (up) or all 0 (down).
  assign t_up[0] = 1'b1;
  assign t_dn[0] = 1'b1;
  generate
    for (genvar i = 1; i < WIDTH; i++) begin : g_tog
      assign t_up[i] = &q[i-1:0];
      assign t_dn[i] = ~|q[i-1:0];
    end
  endgenerate

  always_comb begin
    j_bit = '0;
    k_bit = '0;
    if (load) begin
      j_bit = load_val;
      k_bit = ~load_val;
    end else if (en) begin
      case (mode_s)
        M_UP: begin
          if (oor || at_max) begin
            j_bit = '0;
            k_bit = '1;
          end else begin
            j_bit = t_up;
            k_bit = t_up;
          end
        end
        M_DN: begin
          if (oor) begin
            j_bit = '0;
            k_bit = '1;
          end else if (at_zero) begin
            j_bit = MAX_V;
            k_bit = ~MAX_V;
          end else begin
            j_bit = t_dn;
            k_bit = t_dn;
          end
        end
        M_JK: begin
          j_bit = j_in;
          k_bit = k_in;
        end
        default: begin
          j_bit = '0;
          k_bit = '0;
        end
      endcase
    end
  end

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      jk_mod_counter_bit #(.RST_BIT(RST_V[i])) u_bit (
        .clk (clk),
        .rst (reset_async),
        .j   (j_bit[i]),
        .k   (k_bit[i]),
        .q   (q[i])
      );
    end
  endgenerate

  assign tc = en & ~load & (((mode_s == M_UP) & at_max) | ((mode_s == M_DN) & at_zero));
endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed plus randomized checks of jk_mod_counter, MODULUS=10 and MODULUS=16 builds side by side.

module tb_jk_mod_counter;
  logic       clk = 1'b0;
  logic       reset_async = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] j_in = '0;
  logic [3:0] k_in = '0;
  logic [3:0] q10, q16;
  logic       tc10, tc16;

  int checks = 0;
  int errors = 0;
  int m10 = 0;
  int m16 = 0;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut10 (
    .clk(clk), .reset_async(reset_async), .load(load), .load_val(load_val), .en(en),
    .mode(mode), .j_in(j_in), .k_in(k_in), .q(q10), .tc(tc10));

  jk_mod_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) dut16 (
    .clk(clk), .reset_async(reset_async), .load(load), .load_val(load_val), .en(en),
    .mode(mode), .j_in(j_in), .k_in(k_in), .q(q16), .tc(tc16));

  always #5 clk = ~clk;

  // Reference next-state, straight from the behavioural rules as integers.
  function automatic int ref_next(int cur, int m, logic ld, int lv, logic e, int md, int jj, int kk);
    int r;
    if (ld) return lv;
    if (!e || md == 0) return cur;
    if (md == 1) return (cur + 1 >= m) ? 0 : cur + 1;
    if (md == 2) begin
      if (cur >= m) return 0;
      return (cur == 0) ? m - 1 : cur - 1;
    end
    r = cur;
    for (int b = 0; b < 4; b++) begin
      case ({jj[b], kk[b]})
        2'b01: r = r & ~(1 << b);
        2'b10: r = r | (1 << b);
        2'b11: r = r ^ (1 << b);
        default: r = r;
      endcase
    end
    return r;
  endfunction

  function automatic int ref_tc(int cur, int m, logic ld, logic e, int md);
    if (!e || ld) return 0;
    if (md == 1 && cur == m - 1) return 1;
    if (md == 2 && cur == 0) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_q10"},  32'(q10),  32'(m10));
    chk({tag, "_tc10"}, 32'(tc10), 32'(ref_tc(m10, 10, load, en, int'(mode))));
    chk({tag, "_q16"},  32'(q16),  32'(m16));
    chk({tag, "_tc16"}, 32'(tc16), 32'(ref_tc(m16, 16, load, en, int'(mode))));
  endtask

  // Advance one edge with current inputs, then check just after it.
  task automatic step(input string tag);
    int n10, n16;
    n10 = ref_next(m10, 10, load, int'(load_val), en, int'(mode), int'(j_in), int'(k_in));
    n16 = ref_next(m16, 16, load, int'(load_val), en, int'(mode), int'(j_in), int'(k_in));
    @(posedge clk);
    #1;
    m10 = n10;
    m16 = n16;
    chk_all(tag);
  endtask

  task automatic set_in(input logic ld, input int lv, input logic e, input int md);
    load = ld; load_val = 4'(lv); en = e; mode = 2'(md);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    reset_async = 1'b0;

    // 1: async reset between edges while q=7
    set_in(1, 7, 0, 0);
    step("load7");
    set_in(0, 0, 1, 1);
    #2;
    reset_async = 1'b1;
    #1;
    m10 = 0; m16 = 0;
    chk_all("async_rst");
    set_in(1, 5, 1, 1);
    @(posedge clk);
    #1;
    chk_all("rst_hold");
    reset_async = 1'b0;
    set_in(0, 0, 1, 0);
    #1;
    chk_all("rst_rel");

    // 2: up wrap, 12 edges
    set_in(0, 0, 1, 1);
    for (int i = 0; i < 12; i++) step("up");

    // 3: down wrap from 2
    set_in(1, 2, 1, 2);
    step("ld2");
    set_in(0, 0, 1, 2);
    for (int i = 0; i < 4; i++) step("down");

    // 4: load priority with out-of-range value
    set_in(1, 13, 0, 1);
    step("ld13");
    set_in(0, 0, 1, 1);
    step("oor_up");
    set_in(1, 13, 1, 2);
    step("ld13b");
    set_in(0, 0, 1, 2);
    step("oor_dn");

    // 5: JK bank
    set_in(1, 10, 1, 3);
    step("ld1010");
    set_in(0, 0, 1, 3);
    j_in = 4'b0011; k_in = 4'b0101;
    step("jk");

    // 6: hold via mode 00, then via en=0
    set_in(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("hold_m0");
    set_in(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("hold_en0");

    // Up from 15: 16-build wraps naturally, 10-build treats 15 as out of range
    set_in(1, 15, 1, 1);
    step("ld15");
    set_in(0, 0, 1, 1);
    #1;
    chk_all("tc15");
    step("wrap15");

    // Randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 300; i++) begin
      set_in(($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
             ($urandom_range(0, 5) != 0), int'($urandom_range(0, 3)));
      j_in = 4'($urandom_range(0, 15));
      k_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) begin
        reset_async = 1'b1;
        #1;
        m10 = 0; m16 = 0;
        chk_all("rnd_rst");
        reset_async = 1'b0;
      end
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
